fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares the write port of one async write-side FIFO among NUM_REQ burst producers in the wr_clk domain.
//  Round-robin arbitration with burst lock: a granted requester owns the port until its last beat or MAX_BURST beats.
//  A new burst starts only while the FIFO almost-full flag (fifo_full_level) is low; beats are gated by fifo_full.
//  The source ID is tagged onto every written word so the rd_clk side can demultiplex.
// PARAMETERS
//  NUM_REQ     4   number of requesters, >=2
//  DATA_WIDTH  16  payload width per requester
//  MAX_BURST   16  max beats per grant, >=1
//  TIMEOUT     16  consecutive idle beats (req_valid low) tolerated inside a burst, >=1
//  ID_W        $clog2(NUM_REQ), localparam; FIFO data width = DATA_WIDTH+ID_W
// PORTS
//  rst_n            in   1                    reset: asynchronous, active-low
//  wr_clk           in   1                    clock
//  req_valid        in   NUM_REQ              per-requester beat valid
//  req_data         in   NUM_REQ*DATA_WIDTH   payload, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_last         in   NUM_REQ              final beat of burst, qualified by req_valid
//  req_ready        out  NUM_REQ              beat accepted when req_valid & req_ready
//  fifo_wr_en       out  1                    FIFO write strobe
//  fifo_din         out  DATA_WIDTH+ID_W      {grant ID, payload}
//  fifo_full        in   1                    FIFO full (wr_clk domain)
//  fifo_full_level  in   1                    FIFO almost-full, registered in wr_clk
//  gnt              out  NUM_REQ              one-hot current owner, 0 in IDLE
//  busy             out  1                    state==BURST
//  err_timeout      out  NUM_REQ              1-cycle pulse: owner timed out, grant revoked
// BEHAVIOUR
//  - Reset: state=IDLE, gnt=0, last_id=NUM_REQ-1 (requester 0 first), beat_cnt=0, idle_cnt=0;
//    req_ready=0, fifo_wr_en=0, fifo_din=0, busy=0, err_timeout=0.
//  - IDLE: if |req_valid & ~fifo_full_level, register gnt=rr_pick(req_valid,last_id), last_id=pick, -> BURST.
//    rr priority order: last_id+1, last_id+2, ... mod NUM_REQ. fifo_full_level high: stay IDLE, no grant.
//  - BURST (owner g): req_ready[g] = ~fifo_full; others 0. Combinational: fifo_wr_en = req_valid[g] & ~fifo_full,
//    fifo_din = {g, req_data[g]} when fifo_wr_en, else 0. Zero latency requester->FIFO.
//  - Beat accepted: beat_cnt++, idle_cnt=0. If req_last[g] or beat_cnt==MAX_BURST-1: -> IDLE, beat_cnt=0
//    (both true together: single release). One bubble cycle between bursts; earliest first beat is cycle N+1
//    after req_valid rises in IDLE at cycle N.
//  - fifo_full in BURST: no accept, beat_cnt and idle_cnt hold (stall is not idle).
//  - req_valid[g]=0 & ~fifo_full: idle_cnt++; idle_cnt==TIMEOUT-1 -> IDLE, err_timeout[g]=1 one cycle.
//  - fifo_full_level rising mid-burst does not pause the burst; it only blocks the next grant.
//  - Counters: beat_cnt $clog2(MAX_BURST+1) bits, idle_cnt $clog2(TIMEOUT+1) bits, never wrap.
//  - Input valid/data of non-owners ignored; requesters must hold valid/data until ready (no drop).
//  - rst_n mid-burst: immediate return to reset values; partial burst in FIFO is not tagged further.
//    Requesters share rst_n and restart cleanly.
// STRUCTURE
//  - Shared package/header fifo_arb_pkg: state encodings (ST_IDLE=1'b0, ST_BURST=1'b1), clog2 function,
//    fifo_din field offsets (ID at MSBs).
//  - Sub-module rr_arbiter #(NUM_REQ): combinational req vector + last_id -> one-hot gnt + binary id.
//  - Top: FSM, beat/idle counters, output mux.
// TESTING
//  1 Reset: rst_n=0 -> all outputs 0, gnt=0; first req_valid=4'b1111 -> gnt=4'b0001, then 0010,0100,1000.
//  2 Single burst: req0 sends 3 beats, last on 3rd, fifo_full=0 -> 3 fifo_wr_en, fifo_din={2'd0,data},
//    one IDLE bubble, then next owner.
//  3 MAX_BURST=16, req1 streams 40 beats no last -> grants 16,(other reqs low) 16, 8; bubble after each 16.
//  4 fifo_full pulsed 3 cycles mid-burst -> req_ready=0, no wr_en, beat_cnt frozen, no err_timeout.
//  5 req2 granted, then valid low 16 cycles -> err_timeout=4'b0100 one cycle, gnt -> 0, req3 granted next.
//  6 fifo_full_level=1 with req pending -> stays IDLE; mid-burst assertion -> burst completes, no new grant;
//    rst_n pulsed mid-burst -> immediate IDLE, outputs 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared constants and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    // Ceiling log2; returns 0 for values 0 and 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        if (value > 1) begin
            for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
                w++;
            end
        end
        return w;
    endfunction

    // fifo_din layout: {id, payload}; the ID field starts right above the payload.
    function automatic int unsigned id_lsb(input int unsigned data_width);
        return data_width;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr.sv
// Round-robin picker: first requester after last_id (wrapping) wins.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]        req,
    input  logic [clog2(NUM_REQ)-1:0] last_id,
    output logic [NUM_REQ-1:0]        gnt_c,
    output logic [clog2(NUM_REQ)-1:0] id_c
);

    localparam int unsigned ID_W = clog2(NUM_REQ);

    always_comb begin
        logic            found;
        logic [ID_W-1:0] idx;
        gnt_c = '0;
        id_c  = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = ID_W'((32'(last_id) + off) % NUM_REQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                gnt_c[idx] = 1'b1;
                id_c       = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port among NUM_REQ burst producers with round-robin
// burst-locked grants, beat/idle limits and source-ID tagging.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                                 rst_n,
    input  logic                                 wr_clk,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_data,
    input  logic [NUM_REQ-1:0]                   req_last,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic                                 fifo_wr_en,
    output logic [DATA_WIDTH+clog2(NUM_REQ)-1:0] fifo_din,
    input  logic                                 fifo_full,
    input  logic                                 fifo_full_level,
    output logic [NUM_REQ-1:0]                   gnt,
    output logic                                 busy,
    output logic [NUM_REQ-1:0]                   err_timeout
);

    localparam int unsigned ID_W   = clog2(NUM_REQ);
    localparam int unsigned BEAT_W = clog2(MAX_BURST + 1);
    localparam int unsigned IDLE_W = clog2(TIMEOUT + 1);
    localparam int unsigned ID_LSB = id_lsb(DATA_WIDTH);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    logic [0:0]        state, state_nxt;
    logic [ID_W-1:0]   last_id, last_id_nxt;
    logic [BEAT_W-1:0] beat_cnt, beat_cnt_nxt;
    logic [IDLE_W-1:0] idle_cnt, idle_cnt_nxt;
    logic [NUM_REQ-1:0] gnt_nxt, err_timeout_nxt;

    logic [NUM_REQ-1:0]    arb_gnt_c;
    logic [ID_W-1:0]       arb_id_c;
    logic                  in_burst_c;
    logic                  own_valid_c;
    logic                  own_last_c;
    logic [DATA_WIDTH-1:0] own_data_c;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req     (req_valid),
        .last_id (last_id),
        .gnt_c   (arb_gnt_c),
        .id_c    (arb_id_c)
    );

    // While in BURST, last_id is the current owner.
    assign in_burst_c  = (state == ST_BURST);
    assign own_valid_c = req_valid[last_id];
    assign own_last_c  = req_last[last_id];
    assign busy        = in_burst_c;

    always_comb begin
        own_data_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (32'(last_id) == i) begin
                own_data_c = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Zero-latency write path from the owner to the FIFO.
    always_comb begin
        fifo_wr_en = in_burst_c & own_valid_c & ~fifo_full;
        req_ready  = (in_burst_c && !fifo_full) ? gnt : '0;
        fifo_din   = '0;
        if (fifo_wr_en) begin
            fifo_din[ID_LSB +: ID_W]  = last_id;
            fifo_din[DATA_WIDTH-1:0] = own_data_c;
        end
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            gnt         <= '0;
            last_id     <= ID_W'(NUM_REQ - 1);
            beat_cnt    <= '0;
            idle_cnt    <= '0;
            err_timeout <= '0;
        end else begin
            state       <= state_nxt;
            gnt         <= gnt_nxt;
            last_id     <= last_id_nxt;
            beat_cnt    <= beat_cnt_nxt;
            idle_cnt    <= idle_cnt_nxt;
            err_timeout <= err_timeout_nxt;
        end
    end

    // Grant on idle, release on last beat, beat limit or idle timeout; stalls freeze both counters.
    always_comb begin
        state_nxt       = state;
        gnt_nxt         = gnt;
        last_id_nxt     = last_id;
        beat_cnt_nxt    = beat_cnt;
        idle_cnt_nxt    = idle_cnt;
        err_timeout_nxt = '0;
        unique case (state)
            ST_IDLE: begin
                if (|req_valid && !fifo_full_level) begin
                    state_nxt    = ST_BURST;
                    gnt_nxt      = arb_gnt_c;
                    last_id_nxt  = arb_id_c;
                    beat_cnt_nxt = '0;
                    idle_cnt_nxt = '0;
                end
            end
            ST_BURST: begin
                if (!fifo_full) begin
                    if (own_valid_c) begin
                        idle_cnt_nxt = '0;
                        if (own_last_c || beat_cnt == BEAT_LAST) begin
                            state_nxt    = ST_IDLE;
                            gnt_nxt      = '0;
                            beat_cnt_nxt = '0;
                        end else begin
                            beat_cnt_nxt = beat_cnt + 1'b1;
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        state_nxt       = ST_IDLE;
                        gnt_nxt         = '0;
                        err_timeout_nxt = gnt;
                        beat_cnt_nxt    = '0;
                        idle_cnt_nxt    = '0;
                    end else begin
                        idle_cnt_nxt = idle_cnt + 1'b1;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_fifo_wr_arbiter;

    localparam int NR   = 4;
    localparam int DW   = 16;
    localparam int MAXB = 16;
    localparam int TO   = 16;
    localparam int DINW = DW + 2;

    logic              rst_n;
    logic              wr_clk;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic              fifo_wr_en;
    logic [DINW-1:0]   fifo_din;
    logic              fifo_full;
    logic              fifo_full_level;
    logic [NR-1:0]     gnt;
    logic              busy;
    logic [NR-1:0]     err_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MAXB),
        .TIMEOUT    (TO)
    ) dut (
        .rst_n           (rst_n),
        .wr_clk          (wr_clk),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_last        (req_last),
        .req_ready       (req_ready),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_din        (fifo_din),
        .fifo_full       (fifo_full),
        .fifo_full_level (fifo_full_level),
        .gnt             (gnt),
        .busy            (busy),
        .err_timeout     (err_timeout)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] g, input logic [3:0] r,
                             input logic w, input logic [DINW-1:0] d, input logic b,
                             input logic [3:0] e);
        check({tag, " gnt"},         64'(gnt),         64'(g));
        check({tag, " req_ready"},   64'(req_ready),   64'(r));
        check({tag, " fifo_wr_en"},  64'(fifo_wr_en),  64'(w));
        check({tag, " fifo_din"},    64'(fifo_din),    64'(d));
        check({tag, " busy"},        64'(busy),        64'(b));
        check({tag, " err_timeout"}, 64'(err_timeout), 64'(e));
    endtask

    function automatic logic [DINW-1:0] dn(input int id, input int d);
        return {2'(id), 16'(d)};
    endfunction

    function automatic bit bit_of(input logic [NR-1:0] v, input int i);
        return ((v >> i) & 4'b0001) != 4'b0000;
    endfunction

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        fifo_full = 1'b0;
        fifo_full_level = 1'b0;
        repeat (2) @(posedge wr_clk);
        @(negedge wr_clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Reference model: owner index (-1 when no grant) plus beat/idle tallies.
    int       m_owner;
    int       m_last;
    int       m_beats;
    int       m_idles;
    logic [3:0] m_err;

    task automatic model_reset();
        m_owner = -1;
        m_last  = NR - 1;
        m_beats = 0;
        m_idles = 0;
        m_err   = '0;
    endtask

    task automatic model_eval(output logic [3:0] e_gnt, output logic [3:0] e_ready,
                              output logic e_wr, output logic [DINW-1:0] e_din,
                              output logic e_busy, output logic [3:0] e_err);
        e_gnt = '0; e_ready = '0; e_wr = 1'b0; e_din = '0; e_busy = 1'b0; e_err = m_err;
        if (m_owner >= 0) begin
            e_gnt  = 4'(1 << m_owner);
            e_busy = 1'b1;
            if (!fifo_full) begin
                e_ready = 4'(1 << m_owner);
                if (bit_of(req_valid, m_owner)) begin
                    e_wr  = 1'b1;
                    e_din = dn(m_owner, int'(16'(req_data >> (m_owner * DW))));
                end
            end
        end
    endtask

    task automatic model_step();
        m_err = '0;
        if (m_owner < 0) begin
            if (req_valid != '0 && !fifo_full_level) begin
                for (int k = 1; k <= NR; k++) begin
                    int c;
                    c = (m_last + k) % NR;
                    if (m_owner < 0 && bit_of(req_valid, c)) m_owner = c;
                end
                m_last  = m_owner;
                m_beats = 0;
                m_idles = 0;
            end
        end else if (!fifo_full) begin
            if (bit_of(req_valid, m_owner)) begin
                m_beats++;
                m_idles = 0;
                if (bit_of(req_last, m_owner) || m_beats == MAXB) begin
                    m_owner = -1;
                    m_beats = 0;
                end
            end else begin
                m_idles++;
                if (m_idles == TO) begin
                    m_err   = 4'(1 << m_owner);
                    m_owner = -1;
                    m_beats = 0;
                    m_idles = 0;
                end
            end
        end
    endtask

    typedef struct packed {
        logic [3:0]      valid;
        logic [3:0]      last;
        logic            full;
        logic            lvl;
        logic [3:0]      e_gnt;
        logic [3:0]      e_ready;
        logic            e_wr;
        logic [DINW-1:0] e_din;
        logic            e_busy;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic f,
                                input logic lv, input logic [3:0] g, input logic [3:0] r,
                                input logic w, input logic [DINW-1:0] d, input logic b);
        vec_t x;
        x.valid = v; x.last = l; x.full = f; x.lvl = lv;
        x.e_gnt = g; x.e_ready = r; x.e_wr = w; x.e_din = d; x.e_busy = b;
        return x;
    endfunction

    vec_t tbl[15];

    initial begin
        int acc, t, len, errs, bi, sent, gap, n_err;
        int nb[4];
        bit seen, done, prev_busy;
        logic [3:0] errv;
        bit hold[NR];
        logic [DW-1:0] rq_data[NR];
        bit rq_last[NR];
        int quiet[NR];
        logic [3:0] eg, er, ee;
        logic ew, eb;
        logic [DINW-1:0] ed;

        // Round-robin over four always-valid single-beat requesters, then level/full gating.
        tbl[0]  = mk(4'hF, 4'hF, 0, 0, 4'h0, 4'h0, 0, '0,               0);
        tbl[1]  = mk(4'hF, 4'hF, 0, 0, 4'h1, 4'h1, 1, dn(0, 16'hA000),  1);
        tbl[2]  = mk(4'hF, 4'hF, 0, 0, 4'h0, 4'h0, 0, '0,               0);
        tbl[3]  = mk(4'hF, 4'hF, 0, 0, 4'h2, 4'h2, 1, dn(1, 16'hA001),  1);
        tbl[4]  = mk(4'hF, 4'hF, 0, 0, 4'h0, 4'h0, 0, '0,               0);
        tbl[5]  = mk(4'hF, 4'hF, 0, 0, 4'h4, 4'h4, 1, dn(2, 16'hA002),  1);
        tbl[6]  = mk(4'hF, 4'hF, 0, 0, 4'h0, 4'h0, 0, '0,               0);
        tbl[7]  = mk(4'hF, 4'hF, 0, 0, 4'h8, 4'h8, 1, dn(3, 16'hA003),  1);
        tbl[8]  = mk(4'hF, 4'hF, 0, 0, 4'h0, 4'h0, 0, '0,               0);
        tbl[9]  = mk(4'hF, 4'hF, 0, 0, 4'h1, 4'h1, 1, dn(0, 16'hA000),  1);
        tbl[10] = mk(4'hF, 4'hF, 0, 1, 4'h0, 4'h0, 0, '0,               0);
        tbl[11] = mk(4'hF, 4'hF, 0, 1, 4'h0, 4'h0, 0, '0,               0);
        tbl[12] = mk(4'hF, 4'hF, 0, 0, 4'h0, 4'h0, 0, '0,               0);
        tbl[13] = mk(4'hF, 4'hF, 1, 0, 4'h2, 4'h0, 0, '0,               1);
        tbl[14] = mk(4'hF, 4'hF, 0, 0, 4'h2, 4'h2, 1, dn(1, 16'hA001),  1);

        // Reset values while rst_n is held low.
        rst_n = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0;
        fifo_full = 1'b0; fifo_full_level = 1'b0;
        @(negedge wr_clk);
        check_all("reset", 4'h0, 4'h0, 1'b0, '0, 1'b0, 4'h0);

        do_reset();
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 16'(16'hA000 + i);
        for (int i = 0; i < 15; i++) begin
            req_valid       = tbl[i].valid;
            req_last        = tbl[i].last;
            fifo_full       = tbl[i].full;
            fifo_full_level = tbl[i].lvl;
            @(negedge wr_clk);
            check_all($sformatf("tbl%0d", i), tbl[i].e_gnt, tbl[i].e_ready, tbl[i].e_wr,
                      tbl[i].e_din, tbl[i].e_busy, 4'h0);
            tick();
        end

        // req1 streams 40 beats with no last: bursts of 16, 16, then 8 ended by timeout.
        do_reset();
        bi = -1; sent = 0; gap = 0; n_err = 0; errv = '0; prev_busy = 0;
        for (int i = 0; i < 4; i++) nb[i] = 0;
        for (int c = 0; c < 80; c++) begin
            req_valid = (sent < 40) ? 4'b0010 : 4'b0000;
            req_data  = '0;
            req_data[DW +: DW] = 16'(sent);
            @(negedge wr_clk);
            if (busy && !prev_busy) begin
                if (bi >= 0) check("maxburst bubble", 64'(gap), 64'd1);
                bi++;
            end
            gap = busy ? 0 : gap + 1;
            if (fifo_wr_en) begin
                check("maxburst din", 64'(fifo_din), 64'(dn(1, sent)));
                if (bi >= 0 && bi < 4) nb[bi]++;
                sent++;
            end
            if (err_timeout != '0) begin
                n_err++;
                errv = err_timeout;
            end
            prev_busy = busy;
            tick();
        end
        check("maxburst len0", 64'(nb[0]), 64'd16);
        check("maxburst len1", 64'(nb[1]), 64'd16);
        check("maxburst len2", 64'(nb[2]), 64'd8);
        check("maxburst bursts", 64'(bi), 64'd2);
        check("maxburst err count", 64'(n_err), 64'd1);
        check("maxburst err value", 64'(errv), 64'h2);

        // Stall and idle gaps: full freezes both counters, so no timeout and a 16-beat burst.
        do_reset();
        acc = 0; t = 0; len = 0; errs = 0; seen = 0; done = 0;
        for (int c = 0; c < 70; c++) begin
            if (acc < 16) begin
                if (acc == 10 && t < 25) begin
                    req_valid = 4'b0000;
                    fifo_full = (t >= 10 && t < 20);
                    t++;
                end else begin
                    req_valid = 4'b0001;
                    fifo_full = 1'b0;
                end
            end else begin
                req_valid = 4'b0000;
                fifo_full = 1'b0;
            end
            req_data = '0;
            req_data[DW-1:0] = 16'(acc);
            @(negedge wr_clk);
            if (fifo_full) begin
                check("stall req_ready", 64'(req_ready), 64'h0);
                check("stall wr_en", 64'(fifo_wr_en), 64'h0);
                check("stall busy", 64'(busy), 64'h1);
            end
            if (err_timeout != '0) errs++;
            if (busy) seen = 1;
            else if (seen) done = 1;
            if (fifo_wr_en) begin
                acc++;
                if (!done) len++;
            end
            tick();
        end
        check("stall burst len", 64'(len), 64'd16);
        check("stall err count", 64'(errs), 64'd0);

        // req2 granted then silent: timeout pulse, then req3 wins.
        do_reset();
        req_valid = 4'b0100;
        @(negedge wr_clk);
        check("timeout idle gnt", 64'(gnt), 64'h0);
        tick();
        req_valid = 4'b1000;
        for (int c = 1; c <= TO; c++) begin
            @(negedge wr_clk);
            check($sformatf("timeout c%0d gnt", c), 64'(gnt), 64'h4);
            check($sformatf("timeout c%0d err", c), 64'(err_timeout), 64'h0);
            tick();
        end
        @(negedge wr_clk);
        check("timeout pulse", 64'(err_timeout), 64'h4);
        check("timeout gnt cleared", 64'(gnt), 64'h0);
        check("timeout busy", 64'(busy), 64'h0);
        tick();
        @(negedge wr_clk);
        check("timeout pulse end", 64'(err_timeout), 64'h0);
        check("timeout next owner", 64'(gnt), 64'h8);
        tick();

        // Almost-full rising mid-burst: burst finishes, no new grant until it drops.
        do_reset();
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            req_valid       = (acc < 5) ? 4'b0011 : 4'b0010;
            req_last        = (acc == 4) ? 4'b0001 : 4'b0000;
            fifo_full_level = (acc >= 2);
            @(negedge wr_clk);
            if (acc == 5) check("level hold gnt", 64'(gnt), 64'h0);
            if (fifo_wr_en) acc++;
            tick();
        end
        check("level burst beats", 64'(acc), 64'd5);
        req_valid = 4'b0010; req_last = '0; fifo_full_level = 1'b0;
        @(negedge wr_clk);
        tick();
        @(negedge wr_clk);
        check("level release gnt", 64'(gnt), 64'h2);

        // Asynchronous reset mid-burst, then fresh round-robin start at requester 0.
        req_valid = 4'b1111;
        rst_n = 1'b0;
        #1;
        check_all("midreset", 4'h0, 4'h0, 1'b0, '0, 1'b0, 4'h0);
        @(posedge wr_clk);
        @(negedge wr_clk);
        rst_n = 1'b1;
        tick();
        @(negedge wr_clk);
        check("postreset gnt", 64'(gnt), 64'h1);
        tick();

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int i = 0; i < NR; i++) begin
            hold[i] = 0; rq_data[i] = '0; rq_last[i] = 0; quiet[i] = 0;
        end
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!hold[i]) begin
                    if (quiet[i] > 0) quiet[i]--;
                    else if ($urandom_range(0, 30) == 0) quiet[i] = int'($urandom_range(12, 24));
                    else if ($urandom_range(0, 3) == 0) begin
                        hold[i]    = 1;
                        rq_data[i] = 16'($urandom);
                        rq_last[i] = ($urandom_range(0, 5) == 0);
                    end
                end
                req_valid[i] = hold[i];
                req_last[i]  = hold[i] & rq_last[i];
                req_data[i*DW +: DW] = hold[i] ? rq_data[i] : 16'($urandom);
            end
            fifo_full       = ($urandom_range(0, 6) == 0);
            fifo_full_level = ($urandom_range(0, 9) == 0);
            @(negedge wr_clk);
            model_eval(eg, er, ew, ed, eb, ee);
            check_all($sformatf("rand%0d", c), eg, er, ew, ed, eb, ee);
            for (int i = 0; i < NR; i++) begin
                if (hold[i] && bit_of(er, i)) hold[i] = 0;
            end
            model_step();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
